// File: rtl/btn_pkg.sv
// Shared constants for the push-button capture block: channel indices,
// default channel count and the production debounce interval.
package btn_pkg;
    localparam int BTN_L               = 0;
    localparam int BTN_R               = 1;
    localparam int BTN_D               = 2;
    localparam int NUM_BTN_DEFAULT     = 3;
    localparam int DEBOUNCE_10MS_50MHZ = 500000;
endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, stable-interval counter,
// debounced level and a registered one-cycle pulse on each debounced rise.
module btn_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic rise_pulse
);
    localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_chk_min
        $error("DEBOUNCE_CYCLES must be at least 1");
    end
    if ((DEBOUNCE_CYCLES - 1) >= (2 ** CNT_W)) begin : g_chk_fit
        $error("DEBOUNCE_CYCLES-1 does not fit in CNT_W bits");
    end

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Any sample matching the current level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == TC) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign btn_level  = level_q;
    assign rise_pulse = rise_q;
endmodule

// File: rtl/button_input_capture.sv
// Push-button capture: per-channel debounce plus sticky pressed flags that
// the CPU clears one channel at a time with an acknowledge strobe.
module button_input_capture
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = NUM_BTN_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ,
    parameter int CNT_W           = 20,
    parameter int IDX_W           = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic               ack,
    input  logic [IDX_W-1:0]   ack_idx,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] rise_pulse,
    output logic [NUM_BTN-1:0] pressed
);
    if ((2 ** IDX_W) < NUM_BTN) begin : g_chk_idx
        $error("IDX_W too narrow to address every channel");
    end

    logic [NUM_BTN-1:0] pressed_q, pressed_d;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .btn_raw   (btn_raw[g]),
            .btn_level (btn_level[g]),
            .rise_pulse(rise_pulse[g])
        );
    end

    // Clear first, then set, so a press arriving with its own ack survives.
    always_comb begin
        pressed_d = pressed_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (ack && (ack_idx == IDX_W'(i))) begin
                pressed_d[i] = 1'b0;
            end
            if (rise_pulse[i]) begin
                pressed_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pressed_q <= '0;
        end else begin
            pressed_q <= pressed_d;
        end
    end

    assign pressed = pressed_q;
endmodule

// File: tb/tb_button_input_capture.sv
// Directed bench for button_input_capture with a 4-cycle debounce interval.
module tb_button_input_capture;
    import btn_pkg::*;

    localparam int NB = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic          ack;
    logic [1:0]    ack_idx;
    logic [NB-1:0] btn_level, rise_pulse, pressed;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int rise_cnt;

    button_input_capture #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .IDX_W          (2)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_raw),
        .ack       (ack),
        .ack_idx   (ack_idx),
        .btn_level (btn_level),
        .rise_pulse(rise_pulse),
        .pressed   (pressed)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [NB-1:0] lvl,
                           input logic [NB-1:0] rise, input logic [NB-1:0] prs);
        chk({tag, ".level"},   8'(btn_level),  8'(lvl));
        chk({tag, ".rise"},    8'(rise_pulse), 8'(rise));
        chk({tag, ".pressed"}, 8'(pressed),    8'(prs));
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = '0;
        ack     = 1'b0;
        ack_idx = '0;

        // 1: outputs stay low while buttons move under reset and after release
        #2;
        btn_raw = 3'b111;
        tick(3);
        chk_all("rst_held", 3'b000, 3'b000, 3'b000);
        btn_raw = 3'b000;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_all("rst_rel", 3'b000, 3'b000, 3'b000);
        tick(5);
        chk_all("idle", 3'b000, 3'b000, 3'b000);

        // 2: clean press on L; level must flip on exactly the 6th edge
        btn_raw[BTN_L] = 1'b1;
        tick(5);
        chk_all("l_edge5", 3'b000, 3'b000, 3'b000);
        tick(1);
        chk_all("l_edge6", 3'b001, 3'b001, 3'b000);
        tick(1);
        chk_all("l_edge7", 3'b001, 3'b000, 3'b001);
        btn_raw[BTN_L] = 1'b0;
        rise_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            rise_cnt += int'(rise_pulse[BTN_L]);
        end
        chk("l_rel_early", 8'(btn_level), 8'b001);
        tick(1);
        rise_cnt += int'(rise_pulse[BTN_L]);
        chk_all("l_released", 3'b000, 3'b000, 3'b001);
        chk("l_rel_no_pulse", 8'(rise_cnt), 8'd0);

        // 3: bounce on R: 1,1,1,0 then steady 1
        rise_cnt = 0;
        btn_raw[BTN_R] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            rise_cnt += int'(rise_pulse[BTN_R]);
        end
        btn_raw[BTN_R] = 1'b0;
        tick(1);
        rise_cnt += int'(rise_pulse[BTN_R]);
        btn_raw[BTN_R] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            rise_cnt += int'(rise_pulse[BTN_R]);
        end
        chk("r_bounce_hold", 8'(btn_level), 8'b000);
        tick(1);
        rise_cnt += int'(rise_pulse[BTN_R]);
        chk_all("r_settled", 3'b010, 3'b010, 3'b001);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            rise_cnt += int'(rise_pulse[BTN_R]);
        end
        chk("r_one_pulse", 8'(rise_cnt), 8'd1);
        chk("r_pressed", 8'(pressed), 8'b011);

        // 4: ack decode, out-of-range index, ack on an empty flag
        ack = 1'b1; ack_idx = 2'd1;
        tick(1);
        chk("ack_r", 8'(pressed), 8'b001);
        ack_idx = 2'd3;
        tick(1);
        chk("ack_oob", 8'(pressed), 8'b001);
        ack_idx = 2'd2;
        tick(1);
        chk("ack_empty", 8'(pressed), 8'b001);
        ack_idx = 2'd0;
        tick(1);
        chk("ack_l", 8'(pressed), 8'b000);
        ack = 1'b0;

        // 5: simultaneous L+D press, ack of L landing on the setting edge
        btn_raw = 3'b111;
        tick(6);
        chk_all("ld_rise", 3'b111, 3'b101, 3'b000);
        ack = 1'b1; ack_idx = 2'd0;
        tick(1);
        chk_all("collide", 3'b111, 3'b000, 3'b101);
        ack = 1'b0;

        // 6: reset while L is mid-count, button held across reset
        btn_raw = 3'b000;
        tick(6);
        chk_all("all_rel", 3'b000, 3'b000, 3'b101);
        btn_raw[BTN_L] = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        chk_all("mid_rst", 3'b000, 3'b000, 3'b000);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk_all("post_rst5", 3'b000, 3'b000, 3'b000);
        tick(1);
        chk_all("post_rst6", 3'b001, 3'b001, 3'b000);
        tick(1);
        chk_all("post_rst7", 3'b001, 3'b000, 3'b001);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
